edge_pulse_counter: RTL

//  Downstream consumer of the one-bit buffer/delay stage. Samples the buffered

---
 rtl/counter_pkg.sv | 14 +
 rtl/edge_pulse_counter_if.sv | 25 ++
 rtl/edge_detect.sv | 20 ++
 rtl/edge_pulse_counter.sv | 109 ++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared state encoding for the edge/pulse counter
package counter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        LOW  = ST_LOW,
        HIGH = ST_HIGH
    } state_t;

endpackage

// File: rtl/edge_pulse_counter_if.sv
// rtl/edge_pulse_counter_if.sv - control/result bundle of the edge/pulse counter
interface edge_pulse_counter_if #(
    parameter int CNT_W = 8,
    parameter int LEN_W = 8
);
    logic             in;
    logic             en;
    logic             clr;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic [LEN_W-1:0] high_len;
    logic             len_vld;

    modport master (
        output in, en, clr,
        input  rise, fall, count, overflow, high_len, len_vld
    );

    modport slave (
        input  in, en, clr,
        output rise, fall, count, overflow, high_len, len_vld
    );
endinterface

// File: rtl/edge_detect.sv
// rtl/edge_detect.sv - previous-sample register and rise/fall strobes
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic in_d,
    output logic rise_s,
    output logic fall_s
);

    // Track the previous sample every cycle, independent of enable.
    always_ff @(posedge clk) begin
        if (reset) in_d <= 1'b0;
        else       in_d <= in;
    end

    assign rise_s = in & ~in_d;
    assign fall_s = ~in & in_d;

endmodule

// File: rtl/edge_pulse_counter.sv
// rtl/edge_pulse_counter.sv - rising-edge counter and high-pulse width meter
module edge_pulse_counter
    import counter_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int LEN_W = 8,
    parameter int WRAP  = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    edge_pulse_counter_if.slave  bus
);

    state_t           state;
    logic [LEN_W-1:0] run;
    logic [CNT_W-1:0] count_q;
    logic [LEN_W-1:0] high_len_q;
    logic             overflow_q;
    logic             rise_q;
    logic             fall_q;
    logic             len_vld_q;

    logic in_d;
    logic rise_s;
    logic fall_s;
    logic went_high;
    logic went_low;

    edge_detect u_edge (
        .clk    (clk),
        .reset  (reset),
        .in     (bus.in),
        .in_d   (in_d),
        .rise_s (rise_s),
        .fall_s (fall_s)
    );

    // While disabled the FSM may miss the actual transition; a level that is
    // already steady on the new value still moves the FSM once enabled again.
    assign went_high = rise_s | (bus.in & in_d);
    assign went_low  = fall_s | (~bus.in & ~in_d);

    // FSM, edge counter, run-length meter and one-cycle result strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            run        <= '0;
            count_q    <= '0;
            high_len_q <= '0;
            overflow_q <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            len_vld_q  <= 1'b0;
        end else begin
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            len_vld_q <= 1'b0;

            if (bus.clr) begin
                count_q    <= '0;
                overflow_q <= 1'b0;
                high_len_q <= '0;
            end

            if (bus.en) begin
                case (state)
                    IDLE: begin
                        // A line already high out of reset is never counted.
                        if (!bus.in) state <= LOW;
                    end
                    LOW: begin
                        if (went_high) begin
                            state  <= HIGH;
                            rise_q <= 1'b1;
                            run    <= LEN_W'(1);
                            if (!bus.clr) begin
                                if (&count_q) begin
                                    if (WRAP != 0) count_q <= '0;
                                    overflow_q <= 1'b1;
                                end else begin
                                    count_q <= count_q + 1'b1;
                                end
                            end
                        end
                    end
                    HIGH: begin
                        if (went_low) begin
                            state     <= LOW;
                            fall_q    <= 1'b1;
                            len_vld_q <= 1'b1;
                            if (!bus.clr) high_len_q <= run;
                        end else if (!(&run)) begin
                            run <= run + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.rise     = rise_q;
    assign bus.fall     = fall_q;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;
    assign bus.high_len = high_len_q;
    assign bus.len_vld  = len_vld_q;

endmodule
